// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES command sequencer:
// core register map, CTRL/STATUS bit positions, FSM encoding.
package aes_seq_pkg;

  localparam int unsigned ADDR_CTRL    = 32'h08;
  localparam int unsigned ADDR_STATUS  = 32'h09;
  localparam int unsigned ADDR_CONFIG  = 32'h0a;
  localparam int unsigned ADDR_KEY0    = 32'h10;
  localparam int unsigned ADDR_BLOCK0  = 32'h20;
  localparam int unsigned ADDR_RESULT0 = 32'h30;

  localparam int CTRL_INIT_BIT = 0;
  localparam int CTRL_NEXT_BIT = 1;
  localparam int ST_READY_BIT  = 0;
  localparam int ST_VALID_BIT  = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_KEY,
    S_INIT,
    S_GAP_I,
    S_WAIT_RDY,
    S_BCFG,
    S_BLK,
    S_NEXT,
    S_GAP_N,
    S_WAIT_VLD,
    S_RES,
    S_OUT
  } seq_state_e;

endpackage

// File: rtl/aes_seq_ctrl.sv
// Drives a full AES core transaction (config, key, init, block, next,
// result) from one valid/ready command; returns the result on a response port.
import aes_seq_pkg::*;

module aes_seq_ctrl #(
  parameter int POLL_LIMIT = 1023,
  parameter int ADDR_W     = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [255:0]      cmd_key,
  input  logic              cmd_keylen,
  input  logic              cmd_encdec,
  input  logic              cmd_rekey,
  input  logic [127:0]      cmd_block,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [127:0]      rsp_data,
  output logic              rsp_err,
  output logic              core_cs,
  output logic              core_we,
  output logic [ADDR_W-1:0] core_address,
  output logic [31:0]       core_write_data,
  input  logic [31:0]       core_read_data
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  seq_state_e        r_state;
  logic [2:0]        r_cnt;
  logic [PW-1:0]     r_poll;
  logic              r_key_loaded;
  logic              r_klen_loaded;
  logic [7:0][31:0]  r_key;
  logic [3:0][31:0]  r_block;
  logic              r_keylen;
  logic              r_encdec;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [3:0][31:0]  r_rsp_data;
  logic              r_rsp_err;
  logic              r_cs;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  seq_state_e        w_state_n;
  logic [2:0]        w_cnt_n;
  logic [PW-1:0]     w_poll_n;
  logic              w_timeout;
  logic              w_accept;
  logic              w_need_key;
  logic              w_key_last;
  logic              w_poll_last;
  logic              w_st_rdy;
  logic              w_st_vld;
  logic              w_keylen;
  logic              w_encdec;
  logic              w_cs_n;
  logic              w_we_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic [31:0]       w_wdata_n;

  assign w_accept    = cmd_valid & r_cmd_ready & (r_state == S_IDLE);
  assign w_need_key  = cmd_rekey | ~r_key_loaded
                     | (cmd_keylen != r_klen_loaded);
  assign w_key_last  = (r_cnt == (r_keylen ? 3'd7 : 3'd3));
  assign w_poll_last = (r_poll == PW'(POLL_LIMIT - 1));
  assign w_st_rdy    = core_read_data[ST_READY_BIT];
  assign w_st_vld    = core_read_data[ST_VALID_BIT];
  // CONFIG issued straight out of IDLE must use fields latched that same edge
  assign w_keylen    = (r_state == S_IDLE) ? cmd_keylen : r_keylen;
  assign w_encdec    = (r_state == S_IDLE) ? cmd_encdec : r_encdec;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_poll_n  = r_poll;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_state_n = w_need_key ? S_CFG : S_BCFG;
      S_CFG:
        w_state_n = S_KEY;
      S_KEY:
        if (w_key_last) begin
          w_state_n = S_INIT;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 3'd1;
        end
      S_INIT:
        w_state_n = S_GAP_I;
      S_GAP_I: begin
        w_state_n = S_WAIT_RDY;
        w_poll_n  = '0;
      end
      S_WAIT_RDY:
        if (w_st_rdy) begin
          w_state_n = S_BLK;
        end else if (w_poll_last) begin
          w_state_n = S_OUT;
          w_timeout = 1'b1;
        end else begin
          w_poll_n = r_poll + 1'b1;
        end
      S_BCFG:
        w_state_n = S_BLK;
      S_BLK:
        if (r_cnt == 3'd3) begin
          w_state_n = S_NEXT;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 3'd1;
        end
      S_NEXT:
        w_state_n = S_GAP_N;
      S_GAP_N: begin
        w_state_n = S_WAIT_VLD;
        w_poll_n  = '0;
      end
      S_WAIT_VLD:
        if (w_st_rdy & w_st_vld) begin
          w_state_n = S_RES;
        end else if (w_poll_last) begin
          w_state_n = S_OUT;
          w_timeout = 1'b1;
        end else begin
          w_poll_n = r_poll + 1'b1;
        end
      S_RES:
        if (r_cnt == 3'd3) begin
          w_state_n = S_OUT;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 3'd1;
        end
      S_OUT:
        if (rsp_ready)
          w_state_n = S_IDLE;
      default:
        w_state_n = S_IDLE;
    endcase
  end

  // Bus registers carry the access belonging to the state being entered
  always_comb begin
    w_cs_n    = 1'b0;
    w_we_n    = 1'b0;
    w_addr_n  = '0;
    w_wdata_n = '0;
    case (w_state_n)
      S_CFG, S_BCFG: begin
        w_cs_n    = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = ADDR_W'(ADDR_CONFIG);
        w_wdata_n = {30'b0, w_keylen, w_encdec};
      end
      S_KEY: begin
        w_cs_n    = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = ADDR_W'(ADDR_KEY0) + ADDR_W'(w_cnt_n);
        w_wdata_n = r_key[3'd7 - w_cnt_n];
      end
      S_INIT: begin
        w_cs_n    = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = ADDR_W'(ADDR_CTRL);
        w_wdata_n = 32'(1) << CTRL_INIT_BIT;
      end
      S_WAIT_RDY, S_WAIT_VLD: begin
        w_cs_n   = 1'b1;
        w_addr_n = ADDR_W'(ADDR_STATUS);
      end
      S_BLK: begin
        w_cs_n    = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = ADDR_W'(ADDR_BLOCK0) + ADDR_W'(w_cnt_n);
        w_wdata_n = r_block[2'd3 - w_cnt_n[1:0]];
      end
      S_NEXT: begin
        w_cs_n    = 1'b1;
        w_we_n    = 1'b1;
        w_addr_n  = ADDR_W'(ADDR_CTRL);
        w_wdata_n = 32'(1) << CTRL_NEXT_BIT;
      end
      S_RES: begin
        w_cs_n   = 1'b1;
        w_addr_n = ADDR_W'(ADDR_RESULT0) + ADDR_W'(w_cnt_n);
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_poll        <= '0;
      r_key_loaded  <= 1'b0;
      r_klen_loaded <= 1'b0;
      r_key         <= '0;
      r_block       <= '0;
      r_keylen      <= 1'b0;
      r_encdec      <= 1'b0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_cs          <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_poll      <= w_poll_n;
      r_cs        <= w_cs_n;
      r_we        <= w_we_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_cmd_ready <= (w_state_n == S_IDLE);
      r_rsp_valid <= (w_state_n == S_OUT);
      if (w_accept) begin
        r_key    <= cmd_key;
        r_block  <= cmd_block;
        r_keylen <= cmd_keylen;
        r_encdec <= cmd_encdec;
      end
      if (w_accept && w_need_key)
        r_key_loaded <= 1'b0;
      if (r_state == S_WAIT_RDY && w_state_n == S_BLK) begin
        r_key_loaded  <= 1'b1;
        r_klen_loaded <= r_keylen;
      end
      if (r_state == S_RES)
        r_rsp_data[2'd3 - r_cnt[1:0]] <= core_read_data;
      if (w_timeout) begin
        r_rsp_err    <= 1'b1;
        r_rsp_data   <= '0;
        r_key_loaded <= 1'b0;
      end else if (r_state == S_RES && w_state_n == S_OUT) begin
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_err         = r_rsp_err;
  assign core_cs         = r_cs;
  assign core_we         = r_we;
  assign core_address    = r_addr;
  assign core_write_data = r_wdata;

endmodule
